parallel_tx: RTL and testbench

Byte-wide parallel transmitter. It serialises a 64-bit command word into eight bytes on an 8-bit data bus and qualifies each byte with a software-style strobe, `par_clk`. This is the sending end of the `parallel` command link: it drives the `data`/`par_clk` pins that the `parallel` receiver samples. All outputs are registered, and `par_clk` is generated from `clk` by a programmable divider.

---
 rtl/parallel_tx.sv | 92 +++++++++
 tb/tb_parallel_tx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/parallel_tx.sv
// Byte-wide parallel transmitter: sends a 64-bit command MSB byte first,
// qualifying each byte with a divided-down par_clk strobe.
module parallel_tx #(
  parameter int CLK_DIV   = 4,
  parameter int NUM_BYTES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] command,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [7:0]  data,
  output logic        par_clk
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] STROBE = 2'd2;
  localparam logic [1:0] TRAIL  = 2'd3;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [2:0] IDX_LAST = 3'(NUM_BYTES - 1);

  logic [1:0]  state;
  logic [7:0]  div;
  logic [2:0]  idx;
  logic [55:0] shreg;
  logic        div_end;

  assign div_end = (div == DIV_LAST);

  // Byte 0 goes straight to data; shreg holds the bytes still to send.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      div     <= 8'd0;
      idx     <= 3'd0;
      shreg   <= 56'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      data    <= 8'h00;
      par_clk <= 1'b0;
    end else begin
      done <= 1'b0;
      div  <= div + 8'd1;
      unique case (state)
        IDLE: begin
          div <= 8'd0;
          if (start) begin
            shreg <= command[55:0];
            data  <= command[63:56];
            idx   <= 3'd0;
            busy  <= 1'b1;
            state <= SETUP;
          end
        end
        SETUP: begin
          if (div_end) begin
            div     <= 8'd0;
            par_clk <= 1'b1;
            state   <= STROBE;
          end
        end
        STROBE: begin
          if (div_end) begin
            div     <= 8'd0;
            par_clk <= 1'b0;
            if (idx != IDX_LAST) begin
              idx   <= idx + 3'd1;
              data  <= shreg[55:48];
              shreg <= {shreg[47:0], 8'h00};
              state <= SETUP;
            end else begin
              state <= TRAIL;
            end
          end
        end
        TRAIL: begin
          if (div_end) begin
            div   <= 8'd0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parallel_tx.sv
// Testbench for parallel_tx: frame waveforms checked against a
// cycle-indexed model of the link timing, for D=4 and D=2.
module tb_parallel_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [63:0] command = 64'd0;
  int          sel = 4;

  logic       busy4, done4, pc4, busy2, done2, pc2;
  logic [7:0] data4, data2;
  logic       busy, done, par_clk;
  logic [7:0] data;

  int n_cmp = 0;
  int n_bad = 0;

  parallel_tx #(.CLK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .command(command),
    .start(start && sel == 4),
    .busy(busy4), .done(done4), .data(data4), .par_clk(pc4)
  );

  parallel_tx #(.CLK_DIV(2)) dut2 (
    .clk(clk), .rst(rst), .command(command),
    .start(start && sel == 2),
    .busy(busy2), .done(done2), .data(data2), .par_clk(pc2)
  );

  assign busy    = (sel == 2) ? busy2 : busy4;
  assign done    = (sel == 2) ? done2 : done4;
  assign par_clk = (sel == 2) ? pc2   : pc4;
  assign data    = (sel == 2) ? data2 : data4;

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle n counts from the accepting edge e0.
  function automatic logic exp_pc(int n, int d);
    return n >= 1 && n <= 16 * d && ((n - 1) % (2 * d)) >= d;
  endfunction

  function automatic logic [7:0] exp_byte(int n, int d, logic [63:0] c);
    int i;
    i = (n - 1) / (2 * d);
    if (i > 7) i = 7;
    return c[(63 - 8 * i) -: 8];
  endfunction

  // Starts a frame from IDLE and checks it cycle by cycle, ending in
  // the done cycle without advancing past it.
  task automatic frame(input int d, input logic [63:0] cmd,
                       input bit ign, input bit keep,
                       input logic [63:0] nxt, input string tag);
    logic [63:0] rx;
    logic        prev;
    int          pulses;
    rx = 64'd0;
    prev = 1'b0;
    pulses = 0;
    command = cmd;
    start = 1'b1;
    tick();
    if (!keep) start = 1'b0;
    command = keep ? nxt : ~cmd;
    for (int n = 1; n <= 17 * d + 1; n++) begin
      if (ign && n == 20) begin
        start = 1'b1;
        command = {$urandom, $urandom};
      end
      if (ign && n == 21) start = 1'b0;
      n_cmp += 4;
      if (par_clk !== exp_pc(n, d)) begin
        n_bad++;
        $display("FAIL %s par_clk c%0d: got %b want %b",
                 tag, n, par_clk, exp_pc(n, d));
      end
      if (data !== exp_byte(n, d, cmd)) begin
        n_bad++;
        $display("FAIL %s data c%0d: got %h want %h",
                 tag, n, data, exp_byte(n, d, cmd));
      end
      if (busy !== (n <= 17 * d)) begin
        n_bad++;
        $display("FAIL %s busy c%0d: got %b want %b",
                 tag, n, busy, n <= 17 * d);
      end
      if (done !== (n == 17 * d + 1)) begin
        n_bad++;
        $display("FAIL %s done c%0d: got %b want %b",
                 tag, n, done, n == 17 * d + 1);
      end
      if (par_clk === 1'b1 && !prev) begin
        rx = {rx[55:0], data};
        pulses++;
      end
      prev = (par_clk === 1'b1);
      if (n < 17 * d + 1) tick();
    end
    n_cmp += 2;
    if (rx !== cmd) begin
      n_bad++;
      $display("FAIL %s rx_word: got %h want %h", tag, rx, cmd);
    end
    if (pulses != 8) begin
      n_bad++;
      $display("FAIL %s pulses: got %0d want 8", tag, pulses);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_cmp += 5;
    if (busy4 !== 1'b0) begin
      n_bad++; $display("FAIL reset busy: got %b want 0", busy4);
    end
    if (done4 !== 1'b0) begin
      n_bad++; $display("FAIL reset done: got %b want 0", done4);
    end
    if (pc4 !== 1'b0) begin
      n_bad++; $display("FAIL reset par_clk: got %b want 0", pc4);
    end
    if (data4 !== 8'h00) begin
      n_bad++; $display("FAIL reset data: got %h want 00", data4);
    end
    if (busy2 !== 1'b0 || data2 !== 8'h00) begin
      n_bad++;
      $display("FAIL reset d2: got %b/%h want 0/00", busy2, data2);
    end
  endtask

  task automatic test_single_frame();
    sel = 4;
    frame(4, 64'h0123456789ABCDEF, 1'b0, 1'b0, 64'd0, "single");
  endtask

  task automatic test_ignored_start();
    logic [63:0] c;
    sel = 4;
    tick();
    c = {$urandom, $urandom};
    frame(4, c, 1'b1, 1'b0, 64'd0, "ignored");
    for (int i = 0; i < 30; i++) begin
      tick();
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        n_bad++;
        $display("FAIL ignored_idle c%0d: got %b%b want 00", i, busy, done);
      end
    end
  endtask

  task automatic test_back_to_back();
    sel = 4;
    tick();
    frame(4, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 64'd0, "b2b_ff");
    frame(4, 64'd0, 1'b0, 1'b0, 64'd0, "b2b_00");
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b_idle c%0d: got %b%b want 00", i, busy, done);
      end
    end
  endtask

  task automatic test_mid_reset();
    sel = 4;
    tick();
    command = {$urandom, $urandom};
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n < 30; n++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp += 4;
    if (par_clk !== 1'b0) begin
      n_bad++; $display("FAIL midrst par_clk: got %b want 0", par_clk);
    end
    if (data !== 8'h00) begin
      n_bad++; $display("FAIL midrst data: got %h want 00", data);
    end
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL midrst busy: got %b want 0", busy);
    end
    if (done !== 1'b0) begin
      n_bad++; $display("FAIL midrst done: got %b want 0", done);
    end
    for (int i = 0; i < 60; i++) begin
      tick();
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        n_bad++;
        $display("FAIL midrst_idle c%0d: got %b%b want 00", i, busy, done);
      end
    end
    frame(4, {$urandom, $urandom}, 1'b0, 1'b0, 64'd0, "post_rst");
  endtask

  task automatic test_min_div();
    sel = 2;
    for (int k = 0; k < 3; k++) begin
      tick();
      frame(2, {$urandom, $urandom}, 1'b0, 1'b0, 64'd0, "min_div");
    end
    tick();
    sel = 4;
  endtask

  task automatic test_random();
    sel = 4;
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(1, 4)) tick();
      frame(4, {$urandom, $urandom}, 1'b0, 1'b0, 64'd0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_ignored_start();
    test_back_to_back();
    test_mid_reset();
    test_min_div();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
